perceptron_trainer: RTL and testbench
=====================================

# perceptron_trainer

Sequencer that trains a three-input half-precision perceptron (fixed bias input plus two data inputs) over a four-sample truth table. It time-shares a single external FP16 multiply/add unit through a request/acknowledge handshake, computes each sample's net value, applies the sign-bit activation and the perceptron learning rule, and repeats epochs until one epoch is error-free or the epoch limit is reached. It sits between the training-set registers and the shared FPU; the trained weights it outputs feed the inference neurons.

## Interface
- TAM, 16, operand width (IEEE-754 half precision)
- MAX_EPOCHS, 15, epoch limit, 1..15
- ETA, 16'h3800, learning rate (0.5)
- BIAS_IN, 16'hBA66, constant bias input x0 (≈ -0.8)

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin training; sampled only when not busy
- in1  in  4*TAM  data input 1, sample i at [i*TAM +: TAM]
- in2  in  4*TAM  data input 2, same packing
- d  in  4  desired output, bit i = sample i
- w_init0/1/2  in  TAM each  initial weights, loaded on start
- fpu_req  out  1  FPU operation request
- fpu_op  out  1  0 = multiply, 1 = add
- fpu_a, fpu_b  out  TAM each  FPU operands
- fpu_ack  in  1  result valid this cycle; may be high in the same cycle as fpu_req
- fpu_result  in  TAM  FPU result
- w0, w1, w2  out  TAM each  current weights
- y  out  4  latest prediction per sample
- epoch  out  4  epochs executed in current/last run
- busy  out  1  training in progress
- done  out  1  run finished; held until next start
- converged  out  1  valid with done: last epoch had zero errors

## Operation
- States: IDLE, MUL0, MUL1, MUL2, ADD0, ADD1, DECIDE, UMUL0, UADD0, UMUL1, UADD1, UMUL2, UADD2, NEXT, DONE.
- IDLE/DONE + start: load w_init0..2 into w0..w2; clear epoch, y, sample index k, error flag, done, converged; go MUL0.
- Op states hold fpu_req=1 with stable fpu_op/fpu_a/fpu_b; advance only on the cycle fpu_ack=1, capturing fpu_result. fpu_req=0 in all other states; fpu_ack outside op states is ignored.
- MUL0: p0=BIAS_IN*w0. MUL1: p1=in1[k]*w1. MUL2: p2=in2[k]*w2. ADD0: s=p0+p1. ADD1: v=s+p2.
- DECIDE (1 cycle): y[k] = ~v[15] (+0 gives 1, -0 gives 0). If y[k]==d[k] go NEXT; else set error flag, go UMUL0.
- Update: UMULj computes q=ETA*xj (x0=BIAS_IN, x1=in1[k], x2=in2[k]); UADDj computes wj = wj + q if d[k]=1, else wj + {~q[15], q[14:0]}.
- NEXT (1 cycle): if k<3, k++ and go MUL0. If k==3: epoch++; error flag clear → DONE, converged=1; else if epoch+1==MAX_EPOCHS → DONE, converged=0; else clear error flag, k=0, go MUL0.
- DONE: done=1, busy=0.
- Weights in w0..w2 are the live registers; they change only in UADDj ack cycles.

## Timing
- Reset: state IDLE; fpu_req=0, fpu_op=0, fpu_a=fpu_b=0, w0..w2=0, y=0, epoch=0, busy=0, done=0, converged=0.
- busy=1 from the cycle after start is accepted until the cycle DONE is entered.
- start while busy is ignored; start in DONE restarts and clears done the next cycle.
- With a combinational FPU (ack same cycle): correct sample = 7 cycles (5 ops + DECIDE + NEXT); erroneous sample = 13 cycles.
- Each op state lasts exactly (FPU latency + 1) cycles; results are never captured twice.
- rst_n low mid-run aborts immediately to reset values; no partial weight update survives.

## Configuration
- PTRAIN_BIAS_UPD_EN defined: bias weight w0 is trained (UMUL0/UADD0 executed).
- Undefined: w0 stays at w_init0 for the whole run; UMUL0/UADD0 are skipped (DECIDE error → UMUL1), erroneous sample = 11 cycles with a combinational FPU.

## Test plan
- Reset mid-run (after 20 cycles of training) → all outputs return to reset values; fresh start trains normally.
- OR set, behavioural FP16 combinational FPU, macro defined: in1 samples {0,3C00,0,3C00}, in2 {0,0,3C00,3C00}, d=4'b1110, w_init=0 → done after 4 epochs, converged=1, w0≈0x3666, w1=w2=0x3800, y=4'b1110.
- Same stimulus, FPU ack delayed 3 cycles → identical final weights/epoch; every op state lasts 4 cycles; fpu_req never drops before ack.
- XOR set d=4'b0110 → done with converged=0 and epoch=MAX_EPOCHS (15).
- Macro undefined, OR set, w_init0=0x3C00 → w0 stays 0x3C00 throughout; erroneous samples take 11 cycles.
- start pulsed while busy, and fpu_ack pulsed while fpu_req=0 → both ignored; state and weights unaffected.

Source files
------------

// File: rtl/perceptron_trainer.sv
// Trains a 3-input FP16 perceptron (bias + 2 data inputs) over a 4-sample truth table via a shared FPU.
// Latency: per sample 5 FPU ops + DECIDE + NEXT, plus one multiply/add pair per trained weight on error.
// Backpressure: each op state holds fpu_req with stable operands until fpu_ack; start ignored while busy.
// Option: define PTRAIN_BIAS_UPD_EN to also train the bias weight w0 (otherwise w0 keeps w_init0).
module perceptron_trainer #(
  parameter int              TAM        = 16,
  parameter int              MAX_EPOCHS = 15,
  parameter logic [TAM-1:0]  ETA        = 16'h3800,
  parameter logic [TAM-1:0]  BIAS_IN    = 16'hBA66
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [4*TAM-1:0]   in1,
  input  logic [4*TAM-1:0]   in2,
  input  logic [3:0]         d,
  input  logic [TAM-1:0]     w_init0,
  input  logic [TAM-1:0]     w_init1,
  input  logic [TAM-1:0]     w_init2,
  output logic               fpu_req,
  output logic               fpu_op,
  output logic [TAM-1:0]     fpu_a,
  output logic [TAM-1:0]     fpu_b,
  input  logic               fpu_ack,
  input  logic [TAM-1:0]     fpu_result,
  output logic [TAM-1:0]     w0,
  output logic [TAM-1:0]     w1,
  output logic [TAM-1:0]     w2,
  output logic [3:0]         y,
  output logic [3:0]         epoch,
  output logic               busy,
  output logic               done,
  output logic               converged
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_MUL0   = 4'd1;
  localparam logic [3:0] S_MUL1   = 4'd2;
  localparam logic [3:0] S_MUL2   = 4'd3;
  localparam logic [3:0] S_ADD0   = 4'd4;
  localparam logic [3:0] S_ADD1   = 4'd5;
  localparam logic [3:0] S_DECIDE = 4'd6;
  localparam logic [3:0] S_UMUL0  = 4'd7;
  localparam logic [3:0] S_UADD0  = 4'd8;
  localparam logic [3:0] S_UMUL1  = 4'd9;
  localparam logic [3:0] S_UADD1  = 4'd10;
  localparam logic [3:0] S_UMUL2  = 4'd11;
  localparam logic [3:0] S_UADD2  = 4'd12;
  localparam logic [3:0] S_NEXT   = 4'd13;
  localparam logic [3:0] S_DONE   = 4'd14;

  localparam logic [3:0] EPOCH_LIM = 4'(MAX_EPOCHS);

  logic [3:0]     state;
  logic [1:0]     k;
  logic           err;
  logic [TAM-1:0] acc;      // p0, then s, then v (net value)
  logic [TAM-1:0] p1;
  logic [TAM-1:0] p2;
  logic [TAM-1:0] q;        // eta * x_j for the weight being updated
  logic [TAM-1:0] x1;
  logic [TAM-1:0] x2;
  logic [TAM-1:0] q_signed;
  logic           dk;
  logic           yk;

  // Select the current sample and form the signed learning-rule increment
  always_comb begin
    x1       = in1[int'(k)*TAM +: TAM];
    x2       = in2[int'(k)*TAM +: TAM];
    dk       = d[k];
    yk       = ~acc[TAM-1];
    q_signed = dk ? q : {~q[TAM-1], q[TAM-2:0]};
  end

  // FPU request and operands are a pure function of the state, so they stay stable until ack
  always_comb begin
    fpu_req = 1'b0;
    fpu_op  = 1'b0;
    fpu_a   = '0;
    fpu_b   = '0;
    case (state)
      S_MUL0:  begin fpu_req = 1'b1; fpu_a = BIAS_IN; fpu_b = w0; end
      S_MUL1:  begin fpu_req = 1'b1; fpu_a = x1;      fpu_b = w1; end
      S_MUL2:  begin fpu_req = 1'b1; fpu_a = x2;      fpu_b = w2; end
      S_ADD0:  begin fpu_req = 1'b1; fpu_op = 1'b1; fpu_a = acc; fpu_b = p1; end
      S_ADD1:  begin fpu_req = 1'b1; fpu_op = 1'b1; fpu_a = acc; fpu_b = p2; end
      S_UMUL0: begin fpu_req = 1'b1; fpu_a = ETA; fpu_b = BIAS_IN; end
      S_UADD0: begin fpu_req = 1'b1; fpu_op = 1'b1; fpu_a = w0; fpu_b = q_signed; end
      S_UMUL1: begin fpu_req = 1'b1; fpu_a = ETA; fpu_b = x1; end
      S_UADD1: begin fpu_req = 1'b1; fpu_op = 1'b1; fpu_a = w1; fpu_b = q_signed; end
      S_UMUL2: begin fpu_req = 1'b1; fpu_a = ETA; fpu_b = x2; end
      S_UADD2: begin fpu_req = 1'b1; fpu_op = 1'b1; fpu_a = w2; fpu_b = q_signed; end
      default: ;
    endcase
  end

  // Status flags decode directly from the state
  always_comb begin
    busy = (state != S_IDLE) && (state != S_DONE);
    done = (state == S_DONE);
  end

  // Training sequencer: forward pass, activation, weight update, epoch control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      k         <= 2'd0;
      err       <= 1'b0;
      acc       <= '0;
      p1        <= '0;
      p2        <= '0;
      q         <= '0;
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      y         <= 4'd0;
      epoch     <= 4'd0;
      converged <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            w0        <= w_init0;
            w1        <= w_init1;
            w2        <= w_init2;
            epoch     <= 4'd0;
            y         <= 4'd0;
            k         <= 2'd0;
            err       <= 1'b0;
            converged <= 1'b0;
            state     <= S_MUL0;
          end
        end
        S_MUL0:  if (fpu_ack) begin acc <= fpu_result; state <= S_MUL1; end
        S_MUL1:  if (fpu_ack) begin p1  <= fpu_result; state <= S_MUL2; end
        S_MUL2:  if (fpu_ack) begin p2  <= fpu_result; state <= S_ADD0; end
        S_ADD0:  if (fpu_ack) begin acc <= fpu_result; state <= S_ADD1; end
        S_ADD1:  if (fpu_ack) begin acc <= fpu_result; state <= S_DECIDE; end
        S_DECIDE: begin
          y[k] <= yk;
          if (yk == dk) begin
            state <= S_NEXT;
          end else begin
            err <= 1'b1;
`ifdef PTRAIN_BIAS_UPD_EN
            state <= S_UMUL0;
`else
            state <= S_UMUL1;
`endif
          end
        end
        S_UMUL0: if (fpu_ack) begin q  <= fpu_result; state <= S_UADD0; end
        S_UADD0: if (fpu_ack) begin w0 <= fpu_result; state <= S_UMUL1; end
        S_UMUL1: if (fpu_ack) begin q  <= fpu_result; state <= S_UADD1; end
        S_UADD1: if (fpu_ack) begin w1 <= fpu_result; state <= S_UMUL2; end
        S_UMUL2: if (fpu_ack) begin q  <= fpu_result; state <= S_UADD2; end
        S_UADD2: if (fpu_ack) begin w2 <= fpu_result; state <= S_NEXT; end
        S_NEXT: begin
          if (k != 2'd3) begin
            k     <= k + 2'd1;
            state <= S_MUL0;
          end else begin
            epoch <= epoch + 4'd1;
            if (!err) begin
              converged <= 1'b1;
              state     <= S_DONE;
            end else if (epoch + 4'd1 == EPOCH_LIM) begin
              converged <= 1'b0;
              state     <= S_DONE;
            end else begin
              err   <= 1'b0;
              k     <= 2'd0;
              state <= S_MUL0;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_trainer.sv
// Bench for perceptron_trainer: behavioural FP16 FPU with programmable ack latency plus a reference trainer.
// Latency: checks total busy cycles per run and the duration of every FPU op against the configured latency.
// Backpressure: injects start pulses while busy and stray fpu_ack pulses while fpu_req is low.
module tb_perceptron_trainer;

  localparam logic [15:0] BIAS = 16'hBA66;
  localparam logic [15:0] ETA  = 16'h3800;
`ifdef PTRAIN_BIAS_UPD_EN
  localparam bit BIAS_UPD = 1'b1;
`else
  localparam bit BIAS_UPD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [63:0] in1 = '0;
  logic [63:0] in2 = '0;
  logic [3:0]  d = '0;
  logic [15:0] w_init0 = '0, w_init1 = '0, w_init2 = '0;
  logic        fpu_req, fpu_op, fpu_ack;
  logic [15:0] fpu_a, fpu_b, fpu_result;
  logic [15:0] w0, w1, w2;
  logic [3:0]  y, epoch;
  logic        busy, done, converged;

  int          total = 0;
  int          bad = 0;
  int          lat = 0;
  int          lat_cnt = 0;
  logic        spur_ack = 1'b0;
  int          op_len = 0;
  logic [32:0] op_snap = '0;

  perceptron_trainer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2), .d(d),
    .w_init0(w_init0), .w_init1(w_init1), .w_init2(w_init2),
    .fpu_req(fpu_req), .fpu_op(fpu_op), .fpu_a(fpu_a), .fpu_b(fpu_b),
    .fpu_ack(fpu_ack), .fpu_result(fpu_result),
    .w0(w0), .w1(w1), .w2(w2), .y(y), .epoch(epoch),
    .busy(busy), .done(done), .converged(converged)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- FP16 arithmetic via exact reals, single rounding ----------------
  function automatic real pow2(input int n);
    real r = 1.0;
    if (n >= 0) for (int i = 0; i < n; i++) r = r * 2.0;
    else        for (int i = 0; i < -n; i++) r = r / 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    int  e = int'(h[14:10]);
    real m = real'(int'(h[9:0]));
    real r;
    if (e == 0) r = m * pow2(-24);
    else        r = (m + 1024.0) * pow2(e - 25);
    return h[15] ? -r : r;
  endfunction

  function automatic logic [15:0] r2h(input real x, input logic zsign);
    logic s = (x < 0.0);
    real  a = s ? -x : x;
    real  p = 1.0;
    int   e = 0;
    real  m, fl, fr;
    int   mi;
    if (a == 0.0) return {zsign, 15'd0};
    while (a >= 2.0 * p) begin p = p * 2.0; e++; end
    while (a < p && e > -14) begin p = p / 2.0; e--; end
    m  = a / (p / 1024.0);
    fl = $floor(m);
    fr = m - fl;
    mi = $rtoi(fl);
    if (fr > 0.5 || (fr == 0.5 && (mi % 2) == 1)) mi++;
    if (mi == 2048) begin mi = 1024; e++; end
    if (mi < 1024) return {s, 5'd0, 10'(mi)};
    if (e + 15 >= 31) return {s, 5'h1f, 10'd0};
    return {s, 5'(e + 15), 10'(mi - 1024)};
  endfunction

  function automatic logic [15:0] fmul(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) * h2r(b), a[15] ^ b[15]);
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    return r2h(h2r(a) + h2r(b), a[15] & b[15]);
  endfunction

  // ---------------- External FPU model with programmable latency ----------------
  always_comb fpu_result = fpu_op ? fadd(fpu_a, fpu_b) : fmul(fpu_a, fpu_b);
  assign fpu_ack = spur_ack | (fpu_req & (lat_cnt == lat));

  always @(posedge clk) begin
    if (!fpu_req || fpu_ack) lat_cnt <= 0;
    else                     lat_cnt <= lat_cnt + 1;
  end

  // Every op: operands stable, request held until ack, duration lat+1 cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      op_len = 0;
    end else if (fpu_req) begin
      op_len++;
      if (op_len == 1) op_snap = {fpu_op, fpu_a, fpu_b};
      else check("op_stable", {31'd0, fpu_op, fpu_a, fpu_b}, {31'd0, op_snap});
      if (fpu_ack) begin
        check("op_len", 64'(op_len), 64'(lat + 1));
        op_len = 0;
      end
    end else begin
      check("req_drop", 64'(op_len), 64'd0);
    end
  end

  // ---------------- Reference trainer ----------------
  task automatic model(input logic [63:0] i1, input logic [63:0] i2, input logic [3:0] dd,
                       input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2, input int l,
                       output logic [15:0] o0, output logic [15:0] o1, output logic [15:0] o2,
                       output logic [3:0] oy, output int oep, output bit ocv, output int ocyc);
    logic [15:0] w[3];
    logic [15:0] x[3];
    logic [15:0] net, qq;
    bit          errs;
    w[0] = a0; w[1] = a1; w[2] = a2;
    oy = '0; oep = 0; ocv = 1'b0; ocyc = 0;
    for (int ep = 1; ep <= 15; ep++) begin
      errs = 1'b0;
      for (int s = 0; s < 4; s++) begin
        x[0] = BIAS; x[1] = i1[s*16 +: 16]; x[2] = i2[s*16 +: 16];
        net = fadd(fadd(fmul(x[0], w[0]), fmul(x[1], w[1])), fmul(x[2], w[2]));
        oy[s] = ~net[15];
        ocyc += 5 * (l + 1) + 2;
        if (oy[s] != dd[s]) begin
          errs = 1'b1;
          for (int j = (BIAS_UPD ? 0 : 1); j < 3; j++) begin
            qq   = fmul(ETA, x[j]);
            w[j] = fadd(w[j], dd[s] ? qq : {~qq[15], qq[14:0]});
            ocyc += 2 * (l + 1);
          end
        end
      end
      oep = ep;
      if (!errs) begin ocv = 1'b1; break; end
    end
    o0 = w[0]; o1 = w[1]; o2 = w[2];
  endtask

  // ---------------- One training run, checked against the reference ----------------
  task automatic run_case(input string tag, input logic [63:0] i1, input logic [63:0] i2, input logic [3:0] dd,
                          input logic [15:0] a0, input logic [15:0] a1, input logic [15:0] a2,
                          input int l, input bit disturb);
    logic [15:0] e0, e1, e2;
    logic [3:0]  ey;
    int          eep, ecyc, cyc;
    bit          ecv;
    model(i1, i2, dd, a0, a1, a2, l, e0, e1, e2, ey, eep, ecv, ecyc);
    @(negedge clk);
    lat = l; in1 = i1; in2 = i2; d = dd; w_init0 = a0; w_init1 = a1; w_init2 = a2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check($sformatf("%s_started", tag), {62'd0, done, busy}, 64'd1);
    cyc = 1;
    while (cyc < 6000) begin
      @(negedge clk);
      start = 1'b0; spur_ack = 1'b0;
      if (!busy) break;
      cyc++;
`ifndef PTRAIN_BIAS_UPD_EN
      check($sformatf("%s_w0hold", tag), 64'(w0), 64'(a0));
`endif
      if (disturb && (cyc % 17) == 5) start = 1'b1;
      if (disturb && (cyc % 13) == 7 && !fpu_req) spur_ack = 1'b1;
    end
    start = 1'b0; spur_ack = 1'b0;
    check($sformatf("%s_done", tag), 64'(done), 64'd1);
    check($sformatf("%s_cycles", tag), 64'(cyc), 64'(ecyc));
    check($sformatf("%s_conv", tag), 64'(converged), 64'(ecv));
    check($sformatf("%s_epoch", tag), 64'(epoch), 64'(eep));
    check($sformatf("%s_w0", tag), 64'(w0), 64'(e0));
    check($sformatf("%s_w1", tag), 64'(w1), 64'(e1));
    check($sformatf("%s_w2", tag), 64'(w2), 64'(e2));
    check($sformatf("%s_y", tag), 64'(y), 64'(ey));
  endtask

  function automatic logic [15:0] rnd_h();
    if ($urandom_range(0, 3) == 0) return 16'h0000;
    return {1'($urandom_range(0, 1)), 5'($urandom_range(11, 16)), 10'($urandom)};
  endfunction

  task automatic check_reset_values(input string tag);
    check($sformatf("%s_busy", tag), 64'(busy), 64'd0);
    check($sformatf("%s_done", tag), 64'(done), 64'd0);
    check($sformatf("%s_conv", tag), 64'(converged), 64'd0);
    check($sformatf("%s_epoch", tag), 64'(epoch), 64'd0);
    check($sformatf("%s_y", tag), 64'(y), 64'd0);
    check($sformatf("%s_w", tag), {16'd0, w0, w1, w2}, 64'd0);
    check($sformatf("%s_fpu", tag), {31'd0, fpu_req, fpu_op, fpu_a, fpu_b}, 64'd0);
  endtask

  localparam logic [63:0] OR_IN1 = {16'h3C00, 16'h0000, 16'h3C00, 16'h0000};
  localparam logic [63:0] OR_IN2 = {16'h3C00, 16'h3C00, 16'h0000, 16'h0000};

  initial begin
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;

    // OR set, combinational FPU
    run_case("or_l0", OR_IN1, OR_IN2, 4'b1110, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0);
`ifdef PTRAIN_BIAS_UPD_EN
    check("or_known_epoch", 64'(epoch), 64'd4);
    check("or_known_conv", 64'(converged), 64'd1);
    check("or_known_w", {16'd0, w0, w1, w2}, {16'd0, 16'h3666, 16'h3800, 16'h3800});
    check("or_known_y", 64'(y), 64'hE);
`else
    check("or_known_w0", 64'(w0), 64'd0);
`endif

    // OR set, FPU ack delayed 3 cycles
    run_case("or_l3", OR_IN1, OR_IN2, 4'b1110, 16'h0000, 16'h0000, 16'h0000, 3, 1'b0);

    // XOR set never converges
    run_case("xor", OR_IN1, OR_IN2, 4'b0110, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0);
    check("xor_epoch", 64'(epoch), 64'd15);
    check("xor_conv", 64'(converged), 64'd0);

    // OR with w_init0 = 1.0, with start and stray ack pulses while busy
    run_case("or_w1", OR_IN1, OR_IN2, 4'b1110, 16'h3C00, 16'h0000, 16'h0000, 1, 1'b1);
`ifndef PTRAIN_BIAS_UPD_EN
    check("or_w1_w0", 64'(w0), 64'h3C00);
    check("or_w1_epoch", 64'(epoch), 64'd3);
    check("or_w1_conv", 64'(converged), 64'd1);
`endif

    // Reset in the middle of training, then a fresh run
    @(negedge clk);
    lat = 0; in1 = OR_IN1; in2 = OR_IN2; d = 4'b0110;
    w_init0 = 16'h3C00; w_init1 = 16'h3800; w_init2 = 16'hB800;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    run_case("after_rst", OR_IN1, OR_IN2, 4'b1110, 16'h0000, 16'h0000, 16'h0000, 0, 1'b0);

    // Randomized truth tables, weights and FPU latencies
    for (int r = 0; r < 6; r++) begin
      logic [63:0] ri1, ri2;
      for (int s = 0; s < 4; s++) begin
        ri1[s*16 +: 16] = rnd_h();
        ri2[s*16 +: 16] = rnd_h();
      end
      run_case($sformatf("rnd%0d", r), ri1, ri2, 4'($urandom), rnd_h(), rnd_h(), rnd_h(),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
